// File: rtl/apb_pkg.sv
// Shared definitions for the APB4 slave memory: FSM encoding, wait-mode selectors,
// PPROT bit positions and the wait-state LFSR polynomial/seed.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    localparam int WAIT_MODE_FIXED = 0;
    localparam int WAIT_MODE_LFSR  = 1;

    localparam int PPROT_PRIV_BIT   = 0;
    localparam int PPROT_NONSEC_BIT = 1;
    localparam int PPROT_INSTR_BIT  = 2;

    // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/apb_wait_gen.sv
// Wait-state generator: a constant count in fixed mode, or an LFSR value clamped
// to WAIT_CYCLES that steps once per setup strobe in pseudo-random mode.
module apb_wait_gen
    import apb_pkg::*;
#(
    parameter int WAIT_MODE   = 0,
    parameter int WAIT_CYCLES = 2,
    parameter int SLAVE_ID    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       setup,
    output logic [3:0] wait_cnt
);

    localparam logic [7:0] SEED = LFSR_SEED ^ 8'(SLAVE_ID);
    localparam logic [3:0] WMAX = 4'(WAIT_CYCLES);

    logic [7:0] lfsr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= SEED;
        end else if (setup) begin
            lfsr_reg <= lfsr_step(lfsr_reg);
        end
    end

    generate
        if (WAIT_MODE == WAIT_MODE_LFSR) begin : g_lfsr
            assign wait_cnt = (lfsr_reg[3:0] <= WMAX) ? lfsr_reg[3:0] : WMAX;
        end else begin : g_fixed
            assign wait_cnt = WMAX;
        end
    endgenerate

endmodule

// File: rtl/apb4_slave_mem.sv
// Parametrised APB4 slave RAM with byte strobes, wait states, range/alignment/
// protection error responses and a saturating error counter.
module apb4_slave_mem
    import apb_pkg::*;
#(
    parameter  int ADDR_WIDTH  = 32,
    parameter  int DATA_WIDTH  = 32,
    parameter  int DEPTH       = 256,
    parameter  int SLAVE_ID    = 0,
    parameter  int WAIT_MODE   = 0,
    parameter  int WAIT_CYCLES = 2,
    parameter  int PROT_CHECK  = 0,
    parameter  int SECURE_BASE = DEPTH / 2,
    localparam int STRB_W      = DATA_WIDTH / 8
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [2:0]            PPROT,
    input  logic [STRB_W-1:0]     PSTRB,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [7:0]            err_cnt
);

    localparam int          OFF_W      = $clog2(STRB_W);
    localparam int          MEM_AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] ALIGN_MASK = 16'(STRB_W - 1);
    localparam logic [31:0] LIMIT      = 32'(DEPTH * STRB_W);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_reg;
    logic [3:0]            cnt_reg;
    logic                  pready_reg;
    logic                  slverr_reg;
    logic [DATA_WIDTH-1:0] prdata_reg;
    logic [7:0]            err_cnt_reg;
    logic                  write_reg;
    logic [MEM_AW-1:0]     idx_reg;
    logic [STRB_W-1:0]     strb_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;

    logic [15:0] addr16;
    logic [15:0] word_idx;
    logic        setup;
    logic        range_err;
    logic        align_err;
    logic        prot_err;
    logic        setup_err;
    logic        mem_we;
    logic [3:0]  wait_w;
    logic        unused_bits;

    assign addr16      = PADDR[15:0];
    assign word_idx    = addr16 >> OFF_W;
    assign setup       = (state_reg == ST_IDLE) && PSEL && !PENABLE;
    assign range_err   = {16'd0, addr16} >= LIMIT;
    assign align_err   = |(addr16 & ALIGN_MASK);
    assign prot_err    = (PROT_CHECK != 0) && PPROT[PPROT_NONSEC_BIT]
                         && ({16'd0, word_idx} >= 32'(SECURE_BASE));
    assign setup_err   = range_err || align_err || prot_err;
    assign unused_bits = ^{PADDR, PPROT};

    // The write commits on the completing edge, using the setup-phase payload
    assign mem_we = (state_reg == ST_READY) && PSEL && PENABLE && write_reg && !slverr_reg;

    apb_wait_gen #(
        .WAIT_MODE   (WAIT_MODE),
        .WAIT_CYCLES (WAIT_CYCLES),
        .SLAVE_ID    (SLAVE_ID)
    ) u_wait_gen (
        .clk      (PCLK),
        .rst      (PRESET),
        .setup    (setup),
        .wait_cnt (wait_w)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= 4'd0;
            pready_reg  <= 1'b0;
            slverr_reg  <= 1'b0;
            prdata_reg  <= '0;
            err_cnt_reg <= 8'd0;
            write_reg   <= 1'b0;
            idx_reg     <= '0;
            strb_reg    <= '0;
            wdata_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    pready_reg <= 1'b0;
                    if (setup) begin
                        write_reg  <= PWRITE;
                        idx_reg    <= word_idx[MEM_AW-1:0];
                        strb_reg   <= PSTRB;
                        wdata_reg  <= PWDATA;
                        slverr_reg <= setup_err;
                        if (!PWRITE) begin
                            prdata_reg <= setup_err ? '0 : mem[word_idx[MEM_AW-1:0]];
                        end
                        cnt_reg <= wait_w;
                        if (wait_w == 4'd0) begin
                            state_reg  <= ST_READY;
                            pready_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!PSEL) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= 4'd0;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                        if (cnt_reg == 4'd1) begin
                            state_reg  <= ST_READY;
                            pready_reg <= 1'b1;
                        end
                    end
                end
                ST_READY: begin
                    state_reg  <= ST_IDLE;
                    pready_reg <= 1'b0;
                    if (PSEL && slverr_reg && (err_cnt_reg != 8'hFF)) begin
                        err_cnt_reg <= err_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    pready_reg <= 1'b0;
                end
            endcase
        end
    end

    // No reset on the array so it maps onto RAM; contents survive PRESET
    always_ff @(posedge PCLK) begin
        if (mem_we) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (strb_reg[k]) begin
                    mem[idx_reg][k*8 +: 8] <= wdata_reg[k*8 +: 8];
                end
            end
        end
    end

    assign PRDATA  = prdata_reg;
    assign PREADY  = pready_reg;
    assign PSLVERR = slverr_reg;
    assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_apb4_slave_mem.sv
// Self-checking bench: three slave configurations (zero-wait with protection,
// three fixed waits, LFSR waits) driven over a shared APB bus with per-slave PSEL.
module tb_apb4_slave_mem;

    logic        clk = 1'b0;
    logic        rst_a;
    logic        rst_r;
    logic [31:0] paddr;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [2:0]  pprot;
    logic [3:0]  pstrb;
    logic [31:0] pwdata;
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];
    logic [7:0]  err_cnt [3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] mdl [3][256];
    int          exp_err [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb4_slave_mem #(.DATA_WIDTH(32), .DEPTH(256), .SLAVE_ID(0), .WAIT_MODE(0),
                     .WAIT_CYCLES(0), .PROT_CHECK(1), .SECURE_BASE(128)) dut0 (
        .PCLK(clk), .PRESET(rst_a), .PADDR(paddr), .PSEL(psel[0]), .PENABLE(penable),
        .PWRITE(pwrite), .PPROT(pprot), .PSTRB(pstrb), .PWDATA(pwdata),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]), .err_cnt(err_cnt[0]));

    apb4_slave_mem #(.DATA_WIDTH(32), .DEPTH(256), .SLAVE_ID(1), .WAIT_MODE(0),
                     .WAIT_CYCLES(3), .PROT_CHECK(0)) dut3 (
        .PCLK(clk), .PRESET(rst_a), .PADDR(paddr), .PSEL(psel[1]), .PENABLE(penable),
        .PWRITE(pwrite), .PPROT(pprot), .PSTRB(pstrb), .PWDATA(pwdata),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]), .err_cnt(err_cnt[1]));

    apb4_slave_mem #(.DATA_WIDTH(32), .DEPTH(256), .SLAVE_ID(2), .WAIT_MODE(1),
                     .WAIT_CYCLES(5), .PROT_CHECK(0)) dutr (
        .PCLK(clk), .PRESET(rst_r), .PADDR(paddr), .PSEL(psel[2]), .PENABLE(penable),
        .PWRITE(pwrite), .PPROT(pprot), .PSTRB(pstrb), .PWDATA(pwdata),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]), .err_cnt(err_cnt[2]));

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (strb[k]) r[k*8 +: 8] = nw[k*8 +: 8];
        return r;
    endfunction

    // Starts at a post-edge instant and ends at one, so consecutive calls run back to back
    task automatic xfer(input int d, input logic wr, input logic [15:0] addr,
                        input logic [3:0] strb, input logic [31:0] wdata, input logic [2:0] prot,
                        output logic [31:0] rdata, output logic err, output int waits);
        paddr   = {16'd0, addr};
        psel    = 3'b000;
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        pstrb   = strb;
        pwdata  = wdata;
        pprot   = prot;
        @(posedge clk); #1;
        penable = 1'b1;
        waits   = 0;
        while (pready[d] !== 1'b1 && waits < 40) begin
            @(posedge clk); #1;
            waits++;
        end
        if (waits >= 40) begin
            checks++; failures++;
            $display("FAIL xfer_timeout dut=%0d addr=%h: PREADY never rose within 40 cycles", d, addr);
        end
        rdata = prdata[d];
        err   = pslverr[d];
        @(posedge clk); #1;
        psel    = 3'b000;
        penable = 1'b0;
        $display("txn dut=%0d %s addr=%h strb=%h wdata=%h prot=%0d rdata=%h err=%0d waits=%0d err_cnt=%0d",
                 d, wr ? "WR" : "RD", addr, strb, wdata, prot, rdata, err, waits, err_cnt[d]);
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_r = 1'b1;
        psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = '0;
        pprot = '0; pstrb = '0; pwdata = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (prdata[d] !== 32'd0 || pready[d] !== 1'b0 || pslverr[d] !== 1'b0 || err_cnt[d] !== 8'd0) begin
                failures++;
                $display("FAIL reset_values dut=%0d: got prdata=%h pready=%b pslverr=%b err_cnt=%0d, want all 0",
                         d, prdata[d], pready[d], pslverr[d], err_cnt[d]);
            end
        end
        rst_a = 1'b0; rst_r = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) exp_err[d] = 0;
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd; logic err; int w;
        xfer(0, 1'b1, 16'h0010, 4'hF, 32'hDEADBEEF, 3'b000, rd, err, w);
        mdl[0][4] = 32'hDEADBEEF;
        checks++;
        if (err !== 1'b0 || w != 0) begin
            failures++;
            $display("FAIL zero_wait_write: got err=%b waits=%0d, want err=0 waits=0", err, w);
        end
        xfer(0, 1'b0, 16'h0010, 4'h0, 32'h0, 3'b000, rd, err, w);
        checks++;
        if (rd !== mdl[0][4] || err !== 1'b0 || w != 0) begin
            failures++;
            $display("FAIL zero_wait_read: got rdata=%h err=%b waits=%0d, want %h 0 0", rd, err, w, mdl[0][4]);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] rd; logic err; int w;
        xfer(0, 1'b1, 16'h0014, 4'hF, 32'hAABBCCDD, 3'b000, rd, err, w);
        mdl[0][5] = 32'hAABBCCDD;
        xfer(0, 1'b1, 16'h0014, 4'b0101, 32'h11223344, 3'b000, rd, err, w);
        mdl[0][5] = merge(mdl[0][5], 32'h11223344, 4'b0101);
        xfer(0, 1'b0, 16'h0014, 4'hF, 32'h0, 3'b000, rd, err, w);
        checks++;
        if (rd !== mdl[0][5] || err !== 1'b0) begin
            failures++;
            $display("FAIL strobe_merge: got rdata=%h err=%b, want %h err=0", rd, err, mdl[0][5]);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int w;
        xfer(0, 1'b1, 16'h0000, 4'hF, 32'h0BADF00D, 3'b000, rd, err, w);
        mdl[0][0] = 32'h0BADF00D;
        xfer(0, 1'b1, 16'h0320, 4'hF, 32'h55AA55AA, 3'b000, rd, err, w);
        mdl[0][200] = 32'h55AA55AA;
        xfer(0, 1'b1, 16'h03FC, 4'hF, 32'h600DCAFE, 3'b000, rd, err, w);
        mdl[0][255] = 32'h600DCAFE;

        xfer(0, 1'b0, 16'h0400, 4'hF, 32'h0, 3'b000, rd, err, w);
        exp_err[0]++;
        checks++;
        if (err !== 1'b1 || rd !== 32'd0 || err_cnt[0] !== 8'(exp_err[0])) begin
            failures++;
            $display("FAIL range_err: got err=%b rdata=%h err_cnt=%0d, want 1 0 %0d", err, rd, err_cnt[0], exp_err[0]);
        end
        xfer(0, 1'b1, 16'h0002, 4'hF, 32'hFFFFFFFF, 3'b000, rd, err, w);
        exp_err[0]++;
        checks++;
        if (err !== 1'b1 || err_cnt[0] !== 8'(exp_err[0])) begin
            failures++;
            $display("FAIL misalign_err: got err=%b err_cnt=%0d, want 1 %0d", err, err_cnt[0], exp_err[0]);
        end
        xfer(0, 1'b1, 16'h0320, 4'hF, 32'h12121212, 3'b010, rd, err, w);
        exp_err[0]++;
        checks++;
        if (err !== 1'b1 || err_cnt[0] !== 8'(exp_err[0])) begin
            failures++;
            $display("FAIL prot_err: got err=%b err_cnt=%0d, want 1 %0d", err, err_cnt[0], exp_err[0]);
        end
        xfer(0, 1'b0, 16'h0000, 4'hF, 32'h0, 3'b000, rd, err, w);
        checks++;
        if (rd !== mdl[0][0] || err !== 1'b0) begin
            failures++;
            $display("FAIL misalign_nowrite: got rdata=%h err=%b, want %h 0", rd, err, mdl[0][0]);
        end
        xfer(0, 1'b0, 16'h0320, 4'hF, 32'h0, 3'b000, rd, err, w);
        checks++;
        if (rd !== mdl[0][200] || err !== 1'b0) begin
            failures++;
            $display("FAIL prot_nowrite: got rdata=%h err=%b, want %h 0", rd, err, mdl[0][200]);
        end
        xfer(0, 1'b0, 16'h03FC, 4'hF, 32'h0, 3'b000, rd, err, w);
        checks++;
        if (rd !== mdl[0][255] || err !== 1'b0 || err_cnt[0] !== 8'(exp_err[0])) begin
            failures++;
            $display("FAIL last_word: got rdata=%h err=%b err_cnt=%0d, want %h 0 %0d",
                     rd, err, err_cnt[0], mdl[0][255], exp_err[0]);
        end
        xfer(0, 1'b0, 16'h0010, 4'hF, 32'h0, 3'b010, rd, err, w);
        checks++;
        if (rd !== mdl[0][4] || err !== 1'b0) begin
            failures++;
            $display("FAIL nonsecure_low_ok: got rdata=%h err=%b, want %h 0", rd, err, mdl[0][4]);
        end
    endtask

    task automatic test_waits();
        logic [31:0] rd; logic err; int w;
        xfer(1, 1'b1, 16'h0000, 4'hF, 32'h00001000, 3'b000, rd, err, w);
        mdl[1][0] = 32'h00001000;
        checks++;
        if (w != 3 || err !== 1'b0) begin
            failures++;
            $display("FAIL wait3_write: got waits=%0d err=%b, want 3 0", w, err);
        end
        xfer(1, 1'b0, 16'h0000, 4'hF, 32'h0, 3'b000, rd, err, w);
        checks++;
        if (w != 3 || rd !== mdl[1][0] || err !== 1'b0) begin
            failures++;
            $display("FAIL wait3_read: got waits=%0d rdata=%h err=%b, want 3 %h 0", w, rd, err, mdl[1][0]);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic err; int w;
        xfer(1, 1'b1, 16'h0020, 4'hF, 32'h12345678, 3'b000, rd, err, w);
        mdl[1][8] = 32'h12345678;
        paddr = 32'h20; psel = 3'b010; penable = 1'b0; pwrite = 1'b1;
        pstrb = 4'hF; pwdata = 32'hCAFEF00D; pprot = 3'b000;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 3'b000; penable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (pready[1] !== 1'b0) begin
                failures++;
                $display("FAIL abort_pready cycle=%0d: got pready=%b, want 0", i, pready[1]);
            end
        end
        xfer(1, 1'b0, 16'h0020, 4'hF, 32'h0, 3'b000, rd, err, w);
        checks++;
        if (rd !== mdl[1][8] || err_cnt[1] !== 8'(exp_err[1])) begin
            failures++;
            $display("FAIL abort_nowrite: got rdata=%h err_cnt=%0d, want %h %0d", rd, err_cnt[1], mdl[1][8], exp_err[1]);
        end
    endtask

    task automatic test_stray_enable();
        psel = 3'b001; penable = 1'b1; pwrite = 1'b0; paddr = 32'h10;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (pready[0] !== 1'b0) begin
                failures++;
                $display("FAIL stray_penable cycle=%0d: got pready=%b, want 0", i, pready[0]);
            end
        end
        psel = 3'b000; penable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd0, rd1; logic err; int w; int start;
        start = cyc;
        xfer(0, 1'b1, 16'h0040, 4'hF, 32'hA5A50001, 3'b000, rd0, err, w);
        xfer(0, 1'b1, 16'h0044, 4'hF, 32'hA5A50002, 3'b000, rd0, err, w);
        xfer(0, 1'b0, 16'h0040, 4'hF, 32'h0, 3'b000, rd0, err, w);
        xfer(0, 1'b0, 16'h0044, 4'hF, 32'h0, 3'b000, rd1, err, w);
        mdl[0][16] = 32'hA5A50001;
        mdl[0][17] = 32'hA5A50002;
        checks++;
        if (cyc - start != 8 || rd0 !== mdl[0][16] || rd1 !== mdl[0][17]) begin
            failures++;
            $display("FAIL back_to_back: got cycles=%0d rd=%h,%h, want 8 %h,%h",
                     cyc - start, rd0, rd1, mdl[0][16], mdl[0][17]);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd; logic err; int w; logic [15:0] addr; logic wr;
        logic [3:0] strb; logic [31:0] data; logic exp_e; int kind;
        logic [15:0] seen; bit found;
        seen = '0;
        for (int i = 0; i < 32; i++) begin
            data = $urandom;
            xfer(2, 1'b1, 16'(i * 4), 4'hF, data, 3'b000, rd, err, w);
            mdl[2][i] = data;
            if (w < 16) seen[w] = 1'b1;
            checks++;
            if (err !== 1'b0 || w > 5) begin
                failures++;
                $display("FAIL rand_preload idx=%0d: got err=%b waits=%0d, want 0 and <=5", i, err, w);
            end
        end
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            addr = 16'($urandom_range(0, 31) * 4);
            if (kind == 0) addr = addr | 16'($urandom_range(1, 3));
            if (kind == 1) addr = 16'($urandom_range(256, 16383) * 4);
            wr   = 1'($urandom_range(0, 1));
            strb = 4'($urandom);
            data = $urandom;
            exp_e = (addr >= 16'd1024) || (addr[1:0] != 2'b00);
            xfer(2, wr, addr, strb, data, 3'($urandom), rd, err, w);
            if (w < 16) seen[w] = 1'b1;
            if (exp_e) exp_err[2]++;
            checks++;
            if (err !== exp_e || w > 5 || err_cnt[2] !== 8'(exp_err[2])) begin
                failures++;
                $display("FAIL rand_status n=%0d addr=%h: got err=%b waits=%0d err_cnt=%0d, want %b <=5 %0d",
                         n, addr, err, w, err_cnt[2], exp_e, exp_err[2]);
            end
            if (!wr) begin
                checks++;
                if (rd !== (exp_e ? 32'd0 : mdl[2][addr[9:2]])) begin
                    failures++;
                    $display("FAIL rand_read n=%0d addr=%h: got %h want %h", n, addr, rd,
                             exp_e ? 32'd0 : mdl[2][addr[9:2]]);
                end
            end else if (!exp_e) begin
                mdl[2][addr[9:2]] = merge(mdl[2][addr[9:2]], data, strb);
            end
        end
        checks++;
        if ($countones(seen) < 2 || seen[15:6] != 10'd0) begin
            failures++;
            $display("FAIL rand_wait_spread: got seen-wait mask=%b, want >=2 distinct values all <=5", seen);
        end

        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            paddr = 32'h0C; psel = 3'b100; penable = 1'b0; pwrite = 1'b0; pprot = 3'b000;
            @(posedge clk); #1;
            penable = 1'b1;
            if (pready[2] === 1'b0) begin
                rst_r = 1'b1;
                #1;
                checks++;
                if (pready[2] !== 1'b0 || prdata[2] !== 32'd0 || pslverr[2] !== 1'b0 || err_cnt[2] !== 8'd0) begin
                    failures++;
                    $display("FAIL reset_mid_wait: got pready=%b prdata=%h pslverr=%b err_cnt=%0d, want all 0",
                             pready[2], prdata[2], pslverr[2], err_cnt[2]);
                end
                @(posedge clk); #1;
                rst_r = 1'b0; psel = 3'b000; penable = 1'b0;
                exp_err[2] = 0;
                found = 1'b1;
            end else begin
                @(posedge clk); #1;
                psel = 3'b000; penable = 1'b0;
            end
        end
        if (!found) begin
            checks++; failures++;
            $display("FAIL reset_mid_wait: no transfer with a nonzero wait in 20 tries");
        end
        @(posedge clk); #1;
        xfer(2, 1'b0, 16'h000C, 4'hF, 32'h0, 3'b000, rd, err, w);
        checks++;
        if (rd !== mdl[2][3] || err !== 1'b0 || err_cnt[2] !== 8'd0) begin
            failures++;
            $display("FAIL reset_persist: got rdata=%h err=%b err_cnt=%0d, want %h 0 0", rd, err, err_cnt[2], mdl[2][3]);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_strobe();
        test_errors();
        test_waits();
        test_abort();
        test_stray_enable();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
